// File: rtl/timer_bank_pkg.sv
// Shared definitions for the timer bank: channel state encoding and the
// default period offered to instantiators that need a fixed delay.
package timer_bank_pkg;

    localparam int unsigned TIMR_STATE_W = 2;

    typedef enum logic [TIMR_STATE_W-1:0] {
        TIMR_IDLE_S  = 2'd0,
        TIMR_COUNT_S = 2'd1
    } timr_state_e;

    // Default period for instantiators that tie PERIOD to a constant
    localparam int unsigned TIMR_DEF_PERIOD_C = 1000;

endpackage

// File: rtl/timer_channel.sv
// Single timer channel: one-shot or auto-reload counter with retrigger and
// cancel, emitting a one-cycle registered pulse on terminal count.
//   CLK      system clock, rising edge
//   RST      synchronous active-high reset
//   start    start/retrigger strobe (latches period and periodic)
//   stop     cancel strobe, wins over start
//   periodic mode sampled with start: 1 = auto-reload, 0 = one-shot
//   period   period sampled with start; 0 behaves as 1
//   pulse    registered terminal-count pulse
//   busy     registered, high while counting
//   pulse_c  combinational terminal condition (next value of pulse)
module timer_channel
    import timer_bank_pkg::*;
#(
    parameter int unsigned CNT_W = 21
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             stop,
    input  logic             periodic,
    input  logic [CNT_W-1:0] period,
    output logic             pulse,
    output logic             busy,
    output logic             pulse_c
);

    timr_state_e      state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] period_q;
    logic             periodic_q;

    // Terminal count fires only if neither a cancel nor a retrigger arrives
    assign pulse_c = (state == TIMR_COUNT_S) && (count == period_q) && !start && !stop;

    // Channel state machine
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= TIMR_IDLE_S;
            count      <= '0;
            period_q   <= '0;
            periodic_q <= 1'b0;
            pulse      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            pulse <= pulse_c;
            if (stop) begin
                state <= TIMR_IDLE_S;
                busy  <= 1'b0;
                count <= '0;
            end else if (start) begin
                state      <= TIMR_COUNT_S;
                busy       <= 1'b1;
                count      <= CNT_W'(1);
                // Counter starts at 1, so a zero period is promoted to 1
                period_q   <= (period == '0) ? CNT_W'(1) : period;
                periodic_q <= periodic;
            end else if (state == TIMR_COUNT_S) begin
                if (count == period_q) begin
                    if (periodic_q) begin
                        count <= CNT_W'(1);
                    end else begin
                        state <= TIMR_IDLE_S;
                        busy  <= 1'b0;
                        count <= '0;
                    end
                end else begin
                    count <= count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/timer_bank.sv
// Bank of independent timer channels used as the shared delay/tick source
// for the control FSMs.
//   CLK        system clock, rising edge
//   RST        synchronous active-high reset
//   START      per-channel start/retrigger strobe
//   STOP       per-channel cancel strobe
//   PERIODIC   per-channel mode, sampled with START
//   PERIOD     per-channel period, channel i at [i*CNT_W +: CNT_W]
//   PULSE      per-channel registered terminal-count pulse
//   BUSY       per-channel counting indicator
//   ANY_PULSE  registered OR of all channel pulses, coincident with PULSE
module timer_bank
    import timer_bank_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 21
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NUM_CH-1:0]       START,
    input  logic [NUM_CH-1:0]       STOP,
    input  logic [NUM_CH-1:0]       PERIODIC,
    input  logic [NUM_CH*CNT_W-1:0] PERIOD,
    output logic [NUM_CH-1:0]       PULSE,
    output logic [NUM_CH-1:0]       BUSY,
    output logic                    ANY_PULSE
);

    logic [NUM_CH-1:0] pulse_c;

    // One channel per bit
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        timer_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .CLK      (CLK),
            .RST      (RST),
            .start    (START[i]),
            .stop     (STOP[i]),
            .periodic (PERIODIC[i]),
            .period   (PERIOD[i*CNT_W +: CNT_W]),
            .pulse    (PULSE[i]),
            .busy     (BUSY[i]),
            .pulse_c  (pulse_c[i])
        );
    end

    // Built from the channels' next-pulse terms so it lines up with PULSE
    always_ff @(posedge CLK) begin
        if (RST) begin
            ANY_PULSE <= 1'b0;
        end else begin
            ANY_PULSE <= |pulse_c;
        end
    end

endmodule
